// File: rtl/sid_pot.sv
// sid_pot: SID paddle (POT X/Y) sampler. Each 512-tick period discharges the
// pots for 256 ticks, then times the recharge of each pot. Define SID_POT_FILTER_EN
// for a majority-of-3 glitch filter on the comparator inputs.

package sid;
  localparam int unsigned PHI0 = 0;
  localparam int unsigned PHI1 = 1;
  localparam int unsigned PHI2 = 2;
  localparam int unsigned PHI3 = 3;

  typedef logic [3:0] phase_t;
  typedef logic [8:0] reg9_t;

  typedef struct packed {
    logic [1:0] charged;
  } pot_i_t;

  typedef struct packed {
    logic discharge;
  } pot_o_t;

  typedef struct packed {
    logic [1:0][7:0] xy;
  } pot_reg_t;
endpackage

// One POT channel: first-charge capture plus the published position byte.
module sid_pot_chan (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  sid::reg9_t cnt,
  input  logic       chg_s,
  output logic [7:0] xy
);
  logic       done_q, done_d;
  logic [7:0] val_q, val_d;
  logic [7:0] xy_q, xy_d;
  logic       charged;
  logic       cap;

`ifdef SID_POT_FILTER_EN
  // Window = samples from the two previous ticks plus the current one.
  // Discharge-half samples enter as 0 so a stuck comparator is not remembered.
  logic [1:0] hist_q, hist_d;
  logic       smp;

  always_comb begin
    smp     = chg_s & cnt[8];
    charged = (hist_q[1] & hist_q[0]) | (hist_q[1] & smp) | (hist_q[0] & smp);
    hist_d  = tick ? {hist_q[0], smp} : hist_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= '0;
    else     hist_q <= hist_d;
  end
`else
  always_comb charged = chg_s;
`endif

  always_comb begin
    cap    = tick & cnt[8] & ~done_q & charged;
    done_d = done_q;
    val_d  = val_q;
    xy_d   = xy_q;
    if (cap) begin
      val_d  = cnt[7:0];
      done_d = 1'b1;
    end
    // Wrap tick publishes; a capture on this same tick wins (reads as FF).
    if (tick && cnt == 9'd511) begin
      xy_d   = cap ? cnt[7:0] : (done_q ? val_q : 8'hFF);
      done_d = 1'b0;
      val_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      val_q  <= '0;
      xy_q   <= '0;
    end else begin
      done_q <= done_d;
      val_q  <= val_d;
      xy_q   <= xy_d;
    end
  end

  assign xy = xy_q;
endmodule

module sid_pot (
  input  logic          clk,
  input  logic          rst,
  input  sid::phase_t   phase,
  input  sid::pot_i_t   pot_i,
  output sid::pot_o_t   pot_o,
  output sid::pot_reg_t pot
);
  localparam int NUM_CH = 2;

  logic                   tick;
  logic [3:0]             unused_phase;
  logic [NUM_CH-1:0]      sync1_q, sync2_q;
  logic [NUM_CH-1:0]      chg_s;
  sid::reg9_t             cnt_q, cnt_d;
  logic                   dis_q, dis_d;
  logic [NUM_CH-1:0][7:0] xy;

  assign tick         = phase[sid::PHI1];
  assign unused_phase = phase & ~(4'b0001 << sid::PHI1);
  assign chg_s        = sync2_q;

  // Discharge tracks the half of the period the counter is about to enter.
  always_comb begin
    cnt_d = tick ? cnt_q + 9'd1 : cnt_q;
    dis_d = tick ? ~cnt_d[8] : dis_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      dis_q   <= 1'b1;
    end else begin
      sync1_q <= pot_i.charged;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      dis_q   <= dis_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sid_pot_chan u_chan (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .cnt   (cnt_q),
      .chg_s (chg_s[i]),
      .xy    (xy[i])
    );
  end

  assign pot_o.discharge = dis_q;
  assign pot.xy          = xy;
endmodule

// File: tb/tb_sid_pot.sv
// Randomized/directed bench for sid_pot: per-period comparator levels feed a
// reference model whose expected POT bytes are scoreboarded against publishes.
module tb_sid_pot;
  logic          clk = 1'b0;
  logic          rst;
  sid::phase_t   phase;
  sid::pot_i_t   pot_i;
  sid::pot_o_t   pot_o;
  sid::pot_reg_t pot;

  int checks = 0;
  int errors = 0;
  logic freeze_en = 1'b0;
  logic [15:0] exp_q[$];

  sid_pot dut (
    .clk   (clk),
    .rst   (rst),
    .phase (phase),
    .pot_i (pot_i),
    .pot_o (pot_o),
    .pot   (pot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Level the channel's comparator presents on period tick j (discharge half ignored).
  function automatic logic s_at(input logic [511:0] lv, input int j);
    return (j >= 256) ? lv[j] : 1'b0;
  endfunction

  // Position = ticks into the count half at which charge is first seen, else FF.
  function automatic logic [7:0] ref_pos(input logic [511:0] lv);
    for (int k = 256; k < 512; k++) begin
`ifdef SID_POT_FILTER_EN
      if (int'(s_at(lv, k)) + int'(s_at(lv, k - 1)) + int'(s_at(lv, k - 2)) >= 2)
        return 8'(k - 256);
`else
      if (s_at(lv, k)) return 8'(k - 256);
`endif
    end
    return 8'hFF;
  endfunction

  function automatic logic [511:0] step_from(input int f);
    logic [511:0] v;
    for (int k = 0; k < 512; k++) v[k] = (k >= f);
    return v;
  endfunction

  function automatic logic [511:0] rand_lv();
    logic [511:0] v;
    int f;
    f = int'($urandom_range(200, 620));
    for (int k = 0; k < 512; k++) v[k] = (k >= f) ^ ($urandom_range(0, 19) == 0);
    return v;
  endfunction

  // Phase rotates one-hot; optionally inserts frozen (all-zero) cycles.
  initial begin
    int idx;
    idx   = 0;
    phase = 4'b0001;
    forever begin
      @(negedge clk);
      if (freeze_en && $urandom_range(0, 5) == 0) phase = 4'b0000;
      else begin
        idx   = (idx + 1) % 4;
        phase = 4'(1 << idx);
      end
    end
  end

  // Monitor: a rising discharge marks a publish; pot must hold otherwise.
  initial begin
    logic        prev_dis;
    logic [15:0] last;
    logic [15:0] e;
    prev_dis = 1'b1;
    last     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_dis = pot_o.discharge;
        last     = pot;
      end else begin
        if (pot_o.discharge && !prev_dis) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL publish_unexpected actual=%0h required=none at %0t", pot, $time);
          end else begin
            e = exp_q.pop_front();
            chk("publish", pot, e);
          end
        end else begin
          chk("hold", pot, last);
        end
        last     = pot;
        prev_dis = pot_o.discharge;
      end
    end
  end

  task automatic run_period(input logic [511:0] lx, input logic [511:0] ly, input int abort_at);
    for (int k = 0; k < 512; k++) begin
      pot_i.charged = {ly[k], lx[k]};
      if (k == abort_at) begin
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_pot", pot, 16'h0000);
        chk("midrst_discharge", pot_o.discharge, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        return;
      end
      if (k == 511) exp_q.push_back({ref_pos(ly), ref_pos(lx)});
      do @(posedge clk); while (!phase[sid::PHI1]);
      #1 chk("discharge", pot_o.discharge, ((k + 1) % 512) < 256);
    end
  endtask

  initial begin
    logic [511:0] lx, ly;
    rst   = 1'b1;
    pot_i = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_pot", pot, 16'h0000);
    chk("reset_discharge", pot_o.discharge, 1'b1);
    rst = 1'b0;

    // Idle period: never charged -> FF/FF.
    run_period('0, '0, -1);
    // Basic capture.
    run_period(step_from(356), step_from(263), -1);
    // X charged all period; Y rises only for the last tick.
    ly = '0;
    ly[511] = 1'b1;
    run_period('1, ly, -1);
    // First-capture only on Y; glitch then steady step on X.
    lx = step_from(450);
    lx[320] = 1'b1;
    ly = step_from(400);
    for (int k = 300; k < 310; k++) ly[k] = 1'b1;
    run_period(lx, ly, -1);
    // X captures at 300, then reset at 380 discards the period.
    run_period(step_from(300), '0, 380);
    run_period('0, '0, -1);

    freeze_en = 1'b1;
    for (int p = 0; p < 5; p++) run_period(rand_lv(), rand_lv(), -1);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sid_pot.md
# sid_pot

Paddle (POT X/Y) sampler for the SID core. Each 512-cycle SID measurement period has two halves. In the first half it drives the external POT capacitor discharge line. In the second half it counts SID cycles until each comparator reports "charged". At the end of the period it publishes the two 8-bit positions as the POTX/POTY read-only register bytes. It sits between the board-level POT comparator/discharge pins (`sid::pot_i_t` / `sid::pot_o_t`) and the register read mux, which consumes `sid::pot_reg_t`.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `phase`  in  `sid::phase_t` (4)  one-hot SID clock phase. A SID cycle "tick" is a `clk` cycle with `phase[sid::PHI1]` = 1.
- `pot_i`  in  `sid::pot_i_t` (2)  `charged[0]` = X comparator, `charged[1]` = Y comparator. Asynchronous to `clk`.
- `pot_o`  out  `sid::pot_o_t` (1)  `discharge` = 1 shorts both POT capacitors.
- `pot`  out  `sid::pot_reg_t` (16)  `xy[0]` = POTX, `xy[1]` = POTY.

## Operation
- **Input synchronizer:** 2-flop synchronizer per `charged` bit, clocked every `clk`; output `chg_s[1:0]`.
- **Period counter:** 9-bit `cnt` (`sid::reg9_t`) increments by 1 on each tick and wraps 511 → 0. There is no other state.
- **DISCHARGE half:** `cnt[8]` = 0 (0..255). `discharge` = 1; captures disabled.
- **COUNT half:** `cnt[8]` = 1 (256..511). `discharge` = 0.
- **Per-channel capture** (channel i), on a tick:
  - Condition: `cnt[8]` = 1, `done[i]` = 0, and the channel's charged signal is 1.
  - Action: `val[i]` ← `cnt[7:0]`; `done[i]` ← 1.
  - Only the first charged sample in a period is captured; later ones are ignored.
- **Publish:** on the tick where `cnt` = 511 (wrap), for each channel:
  - `xy[i]` ← `val[i]` if `done[i]`, else 8'hFF (never charged saturates).
  - Same tick also applies: `done` ← 0, `val` ← 0.
  - A capture qualifying on the same tick (`cnt` = 511) takes precedence: publishes 8'hFF (= `cnt[7:0]`).
- **During discharge:** `charged` = 1 in the DISCHARGE half is ignored (stuck comparator) and not remembered.
- **Per-channel behaviour:** channels are fully independent; both capturing on the same tick is legal.
- **Reset values:**
  - `cnt` = 0, `done` = 0, `val` = 0, synchronizer flops = 0.
  - `xy[0]` = `xy[1]` = 8'h00.
  - `discharge` = 1.
- **Reset mid-period:** the period restarts from `cnt` = 0; partial captures are discarded; `xy` returns to 0 until the next publish.

## Timing
- `discharge` is registered; it changes on the `clk` edge of the tick where `cnt` transitions 255 → 256 (falls) and 511 → 0 (rises).
- First publish after reset: 512 ticks after reset release.
- `pot` is registered; it changes only on a publish tick edge and holds for the 512 ticks in between.
- Comparator to capture latency: 2 `clk` (synchronizer) plus up to one tick. An edge arriving fewer than 2 `clk` before a tick is sampled on the following tick.
- Ticks without `phase[PHI1]` leave all state unchanged. A `phase` value with no PHI1 bit freezes the block.

## Configuration
- `SID_POT_FILTER_EN` defined:
  - Each channel's charged signal is the majority-of-3 of `chg_s[i]` sampled on the last three ticks (3-bit shift register per channel, reset 0).
  - Rejects single-tick glitches.
  - A clean step is seen one tick later, so captured values are +1 count vs. unfiltered (saturating at 255).
- `SID_POT_FILTER_EN` not defined:
  - The charged signal is `chg_s[i]` directly.
  - No shift registers are built.

## Test plan
- **Reset state:** assert `rst` asynchronously mid-tick → `discharge` = 1 and `xy` = {00,00} immediately. Release, and with `charged` = 0 run 512 ticks → `xy` = {FF,FF}, `discharge` low for ticks 256..511 only.
- **Basic capture:** raise `charged[0]` ≥3 `clk` before tick `cnt` = 256+100 and `charged[1]` before `cnt` = 256+7, holding both until the period ends → `xy` = {0x64,0x07} after the wrap (filter build: {0x65,0x08}).
- **Boundaries:**
  - `charged` = 1 for the whole period → X captures at `cnt` = 256 → 0x00 (filter: 0x01), and discharge-half assertion is ignored.
  - `charged` rising just before tick 511 → 0xFF.
- **First-capture only:** toggle `charged[1]` high at 300, low at 310, high at 400 → POTY = 0x2C (filter: 0x2D).
- **Mid-period reset:** pulse `rst` at `cnt` = 380 after X has captured → `xy` = 00 until the next full 512-tick period, and the stale X value is not published.
- **Filter build only:** 1-tick glitch on `charged[0]` at 320, then steady high from 450 → POTX = 0xC3 (450−256+1). Unfiltered build publishes 0x40 for the same stimulus.
